// File: rtl/mult_eval_pkg.sv
// Shared definitions for the multiplier evaluation engine: FSM states,
// LFSR polynomial/seed and the statistics counter width.
package mult_eval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Right-shifting Galois taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          CNT_W        = 16;

endpackage

// File: rtl/mult_eval_lfsr.sv
// 16-bit Galois LFSR that steps once per advance pulse; a zero seed would
// lock up, so it is replaced by the default seed.
module mult_eval_lfsr
    import mult_eval_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          OUT_W = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [OUT_W-1:0] slice
);

    localparam logic [15:0] START = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] value_r;
    logic [15:0] value_next_s;

    // next LFSR value: shift right, fold the polynomial in when a one drops out
    always_comb begin
        value_next_s = {1'b0, value_r[15:1]};
        if (value_r[0]) begin
            value_next_s = value_next_s ^ LFSR_POLY;
        end else begin
            value_next_s = value_next_s;
        end
    end

    // LFSR state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= START;
        end else if (advance) begin
            value_r <= value_next_s;
        end else begin
            value_r <= value_r;
        end
    end

    assign slice = value_r[OUT_W-1:0];

endmodule

// File: rtl/mult_eval_engine.sv
// Drives pseudo-random operand pairs into a candidate multiplier, samples the
// product after a settle window, streams each beat and accumulates error stats.
module mult_eval_engine
    import mult_eval_pkg::*;
#(
    parameter int          WIDTH         = 2,
    parameter int          NUM_VECTORS   = 20,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    input  logic [2*WIDTH-1:0]        mul_p,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH-1:0]          res_a,
    output logic [WIDTH-1:0]          res_b,
    output logic [2*WIDTH-1:0]        res_p,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          err_count,
    output logic [2*WIDTH+CNT_W-1:0]  err_sum
);

    localparam int PW   = 2 * WIDTH;
    localparam int SUMW = PW + CNT_W;
    localparam int VW   = $clog2(NUM_VECTORS + 1);
    localparam int SCW  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [VW-1:0]  LAST_VEC    = VW'(NUM_VECTORS - 1);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

    state_t            state_r, state_next_s;
    logic [PW-1:0]     ops_s;
    logic [WIDTH-1:0]  mul_a_r, mul_b_r, res_a_r, res_b_r;
    logic [PW-1:0]     res_p_r;
    logic              res_valid_r, busy_r, done_r;
    logic [CNT_W-1:0]  err_count_r, count_next_s;
    logic [SUMW-1:0]   err_sum_r, sum_next_s;
    logic [VW-1:0]     vec_cnt_r;
    logic [SCW-1:0]    settle_cnt_r;
    logic [PW-1:0]     exact_s, abs_err_s;
    logic              clear_s, accept_s;

    function automatic logic [SUMW-1:0] sat_add(input logic [SUMW-1:0] acc,
                                                input logic [PW-1:0]   inc);
        logic [SUMW:0] wide;
        wide = {1'b0, acc} + {{(SUMW + 1 - PW){1'b0}}, inc};
        if (wide[SUMW]) begin
            sat_add = {SUMW{1'b1}};
        end else begin
            sat_add = wide[SUMW-1:0];
        end
    endfunction

    mult_eval_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (PW)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (accept_s),
        .slice   (ops_s)
    );

    // next-state logic and the clear/accept strobes
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = ST_DRIVE;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DRIVE: state_next_s = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt_r == {SCW{1'b0}}) begin
                    state_next_s = ST_COMPARE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_COMPARE: begin
                if (res_ready) begin
                    accept_s     = 1'b1;
                    state_next_s = (vec_cnt_r == LAST_VEC) ? ST_DONE : ST_DRIVE;
                end else begin
                    state_next_s = ST_COMPARE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // exact product, absolute error and saturating counter updates for the held beat
    always_comb begin
        exact_s = {{WIDTH{1'b0}}, res_a_r} * {{WIDTH{1'b0}}, res_b_r};
        if (exact_s >= res_p_r) begin
            abs_err_s = exact_s - res_p_r;
        end else begin
            abs_err_s = res_p_r - exact_s;
        end
        if ((exact_s != res_p_r) && (err_count_r != {CNT_W{1'b1}})) begin
            count_next_s = err_count_r + CNT_W'(1);
        end else begin
            count_next_s = err_count_r;
        end
        sum_next_s = sat_add(err_sum_r, abs_err_s);
    end

    // state register and status flags derived from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            res_valid_r <= (state_next_s == ST_COMPARE);
            busy_r      <= (state_next_s == ST_DRIVE) || (state_next_s == ST_SETTLE) ||
                           (state_next_s == ST_COMPARE);
            done_r      <= (state_next_s == ST_DONE);
        end
    end

    // operand drive, settle countdown and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_r      <= {WIDTH{1'b0}};
            mul_b_r      <= {WIDTH{1'b0}};
            settle_cnt_r <= {SCW{1'b0}};
            res_a_r      <= {WIDTH{1'b0}};
            res_b_r      <= {WIDTH{1'b0}};
            res_p_r      <= {PW{1'b0}};
        end else if (state_r == ST_DRIVE) begin
            mul_a_r      <= ops_s[WIDTH-1:0];
            mul_b_r      <= ops_s[PW-1:WIDTH];
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == ST_SETTLE) && (settle_cnt_r == {SCW{1'b0}})) begin
            res_a_r <= mul_a_r;
            res_b_r <= mul_b_r;
            res_p_r <= mul_p;
        end else if (state_r == ST_SETTLE) begin
            settle_cnt_r <= settle_cnt_r - SCW'(1);
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // run statistics: cleared on start, updated once per accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r <= {CNT_W{1'b0}};
            err_sum_r   <= {SUMW{1'b0}};
            vec_cnt_r   <= {VW{1'b0}};
        end else if (clear_s) begin
            err_count_r <= {CNT_W{1'b0}};
            err_sum_r   <= {SUMW{1'b0}};
            vec_cnt_r   <= {VW{1'b0}};
        end else if (accept_s) begin
            err_count_r <= count_next_s;
            err_sum_r   <= sum_next_s;
            vec_cnt_r   <= vec_cnt_r + VW'(1);
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign res_valid = res_valid_r;
    assign res_a     = res_a_r;
    assign res_b     = res_b_r;
    assign res_p     = res_p_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_count = err_count_r;
    assign err_sum   = err_sum_r;

endmodule
